clink_seq_ctrl: RTL and testbench

Sequence controller placed directly upstream and downstream of the LSTM inference kernel. It accepts a stream of 16-bit input samples on a valid/ready interface and buffers them in a small FIFO. It issues one kernel start per sample, holding the sample stable until the kernel finishes. Each kernel output is returned on a valid/ready output stream with sequence-boundary marking and per-sequence step counting.

---
 rtl/clink_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_clink_seq_ctrl.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clink_seq_ctrl.sv
// Sequence controller around the LSTM kernel: input FIFO, one kernel start per sample,
// valid/ready result stream with step counting. Optional WAIT watchdog: CLINK_SEQ_TIMEOUT_EN.
module clink_seq_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SEQ_LEN_W      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_data,
  input  logic                 in_last,
  output logic                 clink_start,
  output logic [15:0]          clink_input,
  input  logic                 clink_finish,
  input  logic [15:0]          clink_output,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_data,
  output logic                 out_last,
  output logic [SEQ_LEN_W-1:0] step_count,
  output logic                 seq_done,
  output logic                 busy,
  output logic                 timeout,
  output logic [1:0]           dbg_state
);

  // Handshakes: a transfer happens in any cycle where valid and ready are both high
  // at the rising edge; valid never depends on ready, and data is held while valid waits.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

  state_t state_q, state_d;

  logic [16:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_next;
  logic                 full_q;
  logic                 empty;
  logic                 push, pop;
  logic                 capture_fin, capture_to, hs;
  logic                 wd_expire;
  logic                 last_q;
  logic                 out_valid_q, out_last_q, seq_done_q;
  logic [15:0]          out_data_q;
  logic [SEQ_LEN_W-1:0] step_q;

  assign empty    = (count_q == '0);
  assign in_ready = !full_q;
  assign push     = in_valid && !full_q;

  always_comb begin
    count_next = count_q;
    if (push && !pop)
      count_next = count_q + CW'(1);
    else if (pop && !push)
      count_next = count_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_next;
      full_q  <= (count_next == CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= {in_last, in_data};
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    capture_fin = 1'b0;
    capture_to  = 1'b0;
    hs          = 1'b0;
    clink_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        clink_start = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        // A real finish wins over a watchdog expiry in the same cycle.
        if (clink_finish) begin
          capture_fin = 1'b1;
          state_d     = HOLD;
        end else if (wd_expire) begin
          capture_to = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          hs      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clink_input <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      step_q      <= '0;
      seq_done_q  <= 1'b0;
    end else begin
      if (pop) {last_q, clink_input} <= mem[rd_ptr_q];
      if (capture_fin) begin
        out_data_q  <= clink_output;
        out_last_q  <= last_q;
        out_valid_q <= 1'b1;
      end else if (capture_to) begin
        out_data_q  <= 16'h0000;
        out_last_q  <= last_q;
        out_valid_q <= 1'b1;
      end else if (hs) begin
        out_valid_q <= 1'b0;
      end
      seq_done_q <= hs && out_last_q;
      if (hs) step_q <= out_last_q ? '0 : step_q + SEQ_LEN_W'(1);
    end
  end

`ifdef CLINK_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt_q;
  logic          timeout_q;

  // Counter reads j-1 in the j-th WAIT cycle, so expiry lands on cycle TIMEOUT_CYCLES.
  assign wd_expire = (state_q == WAIT) && !clink_finish &&
                     (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_q != WAIT) wait_cnt_q <= '0;
      else                 wait_cnt_q <= wait_cnt_q + TW'(1);
      if (wd_expire) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign wd_expire          = 1'b0;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign step_count = step_q;
  assign seq_done   = seq_done_q;
  assign busy       = (state_q != IDLE) || !empty;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_clink_seq_ctrl.sv
// Bench for clink_seq_ctrl: kernel responder, push/handshake scoreboard, scenario tasks.
// Define CLINK_SEQ_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_clink_seq_ctrl;

  localparam int FIFO_DEPTH     = 8;
  localparam int SEQ_LEN_W      = 8;
  localparam int TIMEOUT_CYCLES = 16;
  localparam logic [15:0] KEY   = 16'hB9F9;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          in_data;
  logic                 in_last;
  logic                 clink_start;
  logic [15:0]          clink_input;
  logic                 clink_finish;
  logic [15:0]          clink_output;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          out_data;
  logic                 out_last;
  logic [SEQ_LEN_W-1:0] step_count;
  logic                 seq_done;
  logic                 busy;
  logic                 timeout;
  logic [1:0]           dbg_state;

  clink_seq_ctrl #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .SEQ_LEN_W(SEQ_LEN_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .clink_start(clink_start), .clink_input(clink_input),
    .clink_finish(clink_finish), .clink_output(clink_output),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .step_count(step_count), .seq_done(seq_done), .busy(busy), .timeout(timeout),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clock) cyc++;

  // scoreboard: {last, expected result, expected step_count} per accepted sample
  logic [24:0]          exp_q[$];
  logic [15:0]          inp_q[$];
  logic [SEQ_LEN_W-1:0] model_step = '0;
  logic                 force_zero = 1'b0;
  int hs_count = 0, sd_pulses = 0, push_count = 0;
  int last_push_cyc = 0, ov_cyc = 0, hs_cyc = 0;
  logic sd_exp = 1'b0, ov_prev = 1'b0;

  always @(negedge clock) begin
    logic [24:0] e;
    if (reset) begin
      sd_exp  = 1'b0;
      ov_prev = 1'b0;
    end else begin
      total++;
      if (seq_done !== sd_exp) begin
        bad++;
        $display("FAIL seq_done cyc=%0d got=%b required=%b", cyc, seq_done, sd_exp);
      end
      if (seq_done === 1'b1) sd_pulses++;
      sd_exp = 1'b0;
      if (out_valid && !ov_prev) ov_cyc = cyc;
      ov_prev = out_valid;
      if (in_valid && in_ready) begin
        exp_q.push_back({in_last, (force_zero ? 16'h0000 : (in_data ^ KEY)), model_step});
        inp_q.push_back(in_data);
        model_step = in_last ? '0 : model_step + 1'b1;
        push_count++;
        last_push_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        hs_count++;
        hs_cyc = cyc;
        sd_exp = out_last;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_unexpected cyc=%0d got data=%h last=%b required=no result", cyc, out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data, step_count} !== e) begin
            bad++;
            $display("FAIL out_result cyc=%0d got last=%b data=%h step=%0d required last=%b data=%h step=%0d",
                     cyc, out_last, out_data, step_count, e[24], e[23:8], e[7:0]);
          end
        end
      end
    end
  end

  // kernel responder: result = input ^ KEY, kernel_lat cycles after the start pulse
  logic kernel_stall = 1'b0, late_finish_req = 1'b0, k_pending = 1'b0;
  int   kernel_lat = 10, k_cnt = 0, starts = 0, start_cyc = 0, fin_cyc = 0, gap_hs = 0;

  initial begin
    logic [15:0] k_in, exp_in;
    clink_finish = 1'b0;
    clink_output = 16'h0000;
    forever begin
      @(negedge clock);
      clink_finish = 1'b0;
      if (reset) begin
        k_pending = 1'b0;
      end else begin
        if (late_finish_req) begin
          clink_finish    = 1'b1;
          clink_output    = 16'hDEAD;
          late_finish_req = 1'b0;
        end
        if (clink_start) begin
          starts++;
          start_cyc = cyc;
          gap_hs    = cyc - hs_cyc;
          k_in      = clink_input;
          k_pending = 1'b1;
          k_cnt     = kernel_lat;
          total++;
          if (inp_q.size() == 0) begin
            bad++;
            $display("FAIL start_unexpected cyc=%0d got input=%h required=no start", cyc, clink_input);
          end else begin
            exp_in = inp_q.pop_front();
            if (clink_input !== exp_in) begin
              bad++;
              $display("FAIL clink_input cyc=%0d got=%h required=%h", cyc, clink_input, exp_in);
            end
          end
        end else if (k_pending && !kernel_stall) begin
          k_cnt--;
          if (k_cnt <= 0) begin
            k_pending    = 1'b0;
            fin_cyc      = cyc;
            clink_finish = 1'b1;
            clink_output = k_in ^ KEY;
            total++;
            if (clink_input !== k_in) begin
              bad++;
              $display("FAIL clink_input_stable cyc=%0d got=%h required=%h", cyc, clink_input, k_in);
            end
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL push_stuck got in_ready=%b required=1", in_ready);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !busy && !out_valid && !k_pending) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  function automatic logic [46:0] out_vec();
    return {in_ready, clink_start, clink_input, out_valid, out_data, out_last,
            step_count, seq_done, busy, timeout};
  endfunction

  // scenarios
  task automatic test_reset();
    logic [46:0] rst_vals;
    rst_vals = {1'b1, 46'd0};
    reset = 1'b1;
    tick(3);
    @(negedge clock);
    total++;
    if (out_vec() !== rst_vals) begin
      bad++;
      $display("FAIL reset_held got=%h required=%h", out_vec(), rst_vals);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (out_vec() !== rst_vals) begin
      bad++;
      $display("FAIL reset_release got=%h required=%h", out_vec(), rst_vals);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    int sd0, st0;
    bit ok;
    kernel_lat   = 10;
    kernel_stall = 1'b0;
    out_ready    = 1'b1;
    sd0 = sd_pulses;
    st0 = starts;
    push(16'h1234, 1'b1);
    wait_idle(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_drain got=busy required=idle"); end
    total++; if (starts - st0 != 1) begin bad++; $display("FAIL single_starts got=%0d required=1", starts - st0); end
    total++; if (start_cyc - last_push_cyc != 2) begin bad++; $display("FAIL single_start_latency got=%0d required=2", start_cyc - last_push_cyc); end
    total++; if (ov_cyc - fin_cyc != 1) begin bad++; $display("FAIL single_out_latency got=%0d required=1", ov_cyc - fin_cyc); end
    total++; if (step_count !== '0) begin bad++; $display("FAIL single_step got=%0d required=0", step_count); end
    total++; if (sd_pulses - sd0 != 1) begin bad++; $display("FAIL single_seq_done got=%0d required=1", sd_pulses - sd0); end
  endtask

  task automatic test_sequence();
    int sd0, st0, hs0;
    bit ok;
    kernel_lat = $urandom_range(1, 6);
    out_ready  = 1'b1;
    sd0 = sd_pulses; st0 = starts; hs0 = hs_count;
    for (int i = 0; i < 5; i++) push(16'($urandom), (i == 4));
    wait_idle(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL seq_drain got=busy required=idle"); end
    total++; if (starts - st0 != 5) begin bad++; $display("FAIL seq_starts got=%0d required=5", starts - st0); end
    total++; if (hs_count - hs0 != 5) begin bad++; $display("FAIL seq_handshakes got=%0d required=5", hs_count - hs0); end
    total++; if (sd_pulses - sd0 != 1) begin bad++; $display("FAIL seq_seq_done got=%0d required=1", sd_pulses - sd0); end
    total++; if (gap_hs != 2) begin bad++; $display("FAIL seq_restart_gap got=%0d required=2", gap_hs); end
    total++; if (step_count !== '0) begin bad++; $display("FAIL seq_step got=%0d required=0", step_count); end
  endtask

  task automatic test_fill();
    int c0, st0, pc0;
    bit ok;
    kernel_stall = 1'b1;
    kernel_lat   = 2;
    out_ready    = 1'b1;
    st0 = starts;
    c0  = cyc;
    for (int i = 0; i < 9; i++) push(16'($urandom), (i == 8));
    total++; if (last_push_cyc - c0 != 8) begin bad++; $display("FAIL fill_back_to_back got=%0d required=8", last_push_cyc - c0); end
    pc0 = push_count;
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b required=0", in_ready); end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    total++; if (push_count != pc0) begin bad++; $display("FAIL fill_overflow got=%0d required=%0d", push_count, pc0); end
    total++; if (starts - st0 != 1) begin bad++; $display("FAIL fill_starts got=%0d required=1", starts - st0); end
    kernel_stall = 1'b0;
    wait_idle(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL fill_drain got=busy required=idle"); end
    total++; if (starts - st0 != 9) begin bad++; $display("FAIL fill_total_starts got=%0d required=9", starts - st0); end
  endtask

  task automatic test_backpressure();
    int st0, n;
    bit ok;
    logic [15:0] exp_d;
    kernel_lat = 3;
    out_ready  = 1'b0;
    for (int i = 0; i < 3; i++) push(16'($urandom), (i == 2));
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 100) begin n++; @(negedge clock); end
    @(posedge clock); #1;
    st0 = starts;
    exp_d = (exp_q.size() != 0) ? exp_q[0][23:8] : 16'hXXXX;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_d || starts != st0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got valid=%b data=%h starts=%0d required valid=1 data=%h starts=%0d",
                 cyc, out_valid, out_data, starts, exp_d, st0);
      end
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    wait_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_drain got=busy required=idle"); end
    total++; if (starts - st0 != 2) begin bad++; $display("FAIL bp_resume got=%0d required=2", starts - st0); end
  endtask

  task automatic test_random();
    int hs0, pc0;
    bit done, ok;
    done = 1'b0;
    hs0 = hs_count;
    pc0 = push_count;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          kernel_lat = $urandom_range(1, 8);
          push(16'($urandom), 1'($urandom_range(0, 3) == 0));
          if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 4));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    out_ready = 1'b1;
    push(16'($urandom), 1'b1);
    wait_idle(1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL rand_drain got=busy required=idle"); end
    total++; if (hs_count - hs0 != push_count - pc0) begin bad++; $display("FAIL rand_count got=%0d required=%0d", hs_count - hs0, push_count - pc0); end
    total++; if (step_count !== '0) begin bad++; $display("FAIL rand_step got=%0d required=0", step_count); end
  endtask

  task automatic test_step_wrap();
    int hs0, sd0;
    bit ok;
    kernel_lat = 1;
    out_ready  = 1'b1;
    hs0 = hs_count;
    sd0 = sd_pulses;
    for (int i = 0; i < 300; i++) push(16'($urandom), (i == 299));
    wait_idle(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_drain got=busy required=idle"); end
    total++; if (hs_count - hs0 != 300) begin bad++; $display("FAIL wrap_count got=%0d required=300", hs_count - hs0); end
    total++; if (sd_pulses - sd0 != 1) begin bad++; $display("FAIL wrap_seq_done got=%0d required=1", sd_pulses - sd0); end
    total++; if (step_count !== '0) begin bad++; $display("FAIL wrap_step got=%0d required=0", step_count); end
  endtask

  task automatic test_reset_in_wait();
    int st0;
    logic [46:0] rst_vals;
    rst_vals = {1'b1, 46'd0};
    kernel_stall = 1'b1;
    kernel_lat   = 4;
    out_ready    = 1'b1;
    st0 = starts;
    push(16'h0A0A, 1'b0);
    push(16'h0B0B, 1'b0);
    push(16'h0C0C, 1'b1);
    tick(4);
    total++; if (starts - st0 != 1) begin bad++; $display("FAIL rst_wait_started got=%0d required=1", starts - st0); end
    reset = 1'b1;
    exp_q.delete();
    inp_q.delete();
    model_step = '0;
    tick(2);
    reset        = 1'b0;
    kernel_stall = 1'b0;
    late_finish_req = 1'b1;
    tick(4);
    @(negedge clock);
    total++;
    if (out_vec() !== rst_vals) begin
      bad++;
      $display("FAIL rst_wait_outputs got=%h required=%h", out_vec(), rst_vals);
    end
    total++; if (starts - st0 != 1) begin bad++; $display("FAIL rst_wait_restart got=%0d required=1", starts - st0); end
    @(posedge clock); #1;
  endtask

`ifdef CLINK_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int st0, n;
    bit ok;
    kernel_stall = 1'b1;
    kernel_lat   = 5;
    out_ready    = 1'b0;
    force_zero   = 1'b1;
    st0 = starts;
    push(16'h5555, 1'b1);
    force_zero = 1'b0;
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 100) begin n++; @(negedge clock); end
    total++; if (ov_cyc - start_cyc != TIMEOUT_CYCLES + 1) begin bad++; $display("FAIL to_latency got=%0d required=%0d", ov_cyc - start_cyc, TIMEOUT_CYCLES + 1); end
    total++; if (out_data !== 16'h0000 || timeout !== 1'b1) begin bad++; $display("FAIL to_flag got data=%h timeout=%b required data=0000 timeout=1", out_data, timeout); end
    @(posedge clock); #1;
    kernel_stall = 1'b0;
    tick(10);
    @(negedge clock);
    total++; if (out_valid !== 1'b1 || out_data !== 16'h0000) begin bad++; $display("FAIL to_late_finish got valid=%b data=%h required valid=1 data=0000", out_valid, out_data); end
    @(posedge clock); #1;
    out_ready  = 1'b1;
    kernel_lat = 3;
    push(16'h6666, 1'b1);
    wait_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_drain got=busy required=idle"); end
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b required=1", timeout); end
    total++; if (starts - st0 != 2) begin bad++; $display("FAIL to_next got=%0d required=2", starts - st0); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_watchdog cyc=%0d got=running required=finished", cyc);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_sequence();
    test_fill();
    test_backpressure();
    test_random();
    test_step_wrap();
    test_reset_in_wait();
`ifdef CLINK_SEQ_TIMEOUT_EN
    test_timeout();
`else
    total++;
    if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_tied got=%b required=0", timeout); end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
